// File: rtl/mux_pkg.sv
// mux_pkg: shared widths and select type for the mux tree cells
package mux_pkg;
  localparam int MUX_DEFAULT_WIDTH = 64;
  localparam int MUX4_SEL_W = 2;
  typedef logic [MUX4_SEL_W-1:0] mux4_sel_t;
endpackage

// File: rtl/mux2_1.sv
// mux2_1: WIDTH-bit 2:1 combinational leaf cell
module mux2_1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [1:0][WIDTH-1:0] mux_in,
  input  logic                  sel,
  output logic [WIDTH-1:0]      mux_out
);
  assign mux_out = sel ? mux_in[1] : mux_in[0];
endmodule

// File: rtl/mux4_1.sv
// mux4_1: WIDTH-bit 4:1 mux tree with registered output and valid flag
// Optional registered parity output mux_par when MUX4_1_PARITY_EN is defined.
module mux4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0][WIDTH-1:0] mux_in,
  input  mux4_sel_t             sel,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      mux_out_comb,
  output logic [WIDTH-1:0]      mux_out,
  output logic                  out_valid
`ifdef MUX4_1_PARITY_EN
  ,
  output logic                  mux_par
`endif
);
  logic [WIDTH-1:0] a, b;
  mux2_1 #(.WIDTH(WIDTH)) u_leaf_a (.mux_in(mux_in[1:0]), .sel(sel[0]), .mux_out(a));
  mux2_1 #(.WIDTH(WIDTH)) u_leaf_b (.mux_in(mux_in[3:2]), .sel(sel[0]), .mux_out(b));
  mux2_1 #(.WIDTH(WIDTH)) u_root (.mux_in({b, a}), .sel(sel[1]), .mux_out(mux_out_comb));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mux_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) mux_out <= mux_out_comb;
      out_valid <= in_valid;
    end
`ifdef MUX4_1_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mux_par <= 1'b0;
    else if (in_valid) mux_par <= ^mux_out_comb;
`endif
endmodule

// File: tb/tb_mux4_1.sv
// tb_mux4_1: randomized self-checking bench for mux4_1 against a behavioural model
module tb_mux4_1;
  localparam int W = 64;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0]      sel = 2'd0;
  logic [W-1:0]    d [4];
  logic [3:0][W-1:0] mux_in;
  logic [W-1:0]    mux_out_comb, mux_out;
  logic            out_valid;
`ifdef MUX4_1_PARITY_EN
  logic            mux_par;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_out = '0;
  logic         exp_valid = 1'b0;

  always #5 clk = ~clk;
  assign mux_in = {d[3], d[2], d[1], d[0]};

  mux4_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mux_in(mux_in), .sel(sel), .in_valid(in_valid),
    .mux_out_comb(mux_out_comb), .mux_out(mux_out), .out_valid(out_valid)
`ifdef MUX4_1_PARITY_EN
    , .mux_par(mux_par)
`endif
  );

  // Model: on each rising edge the register takes the selected word if valid.
  task automatic edge_cycle();
    @(posedge clk);
    if (rst_n) begin
      if (in_valid) exp_out = d[sel];
      exp_valid = in_valid;
    end else begin
      exp_out = '0;
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    d[0] = 64'hAAAA_0000; d[1] = 64'hBBBB_0001; d[2] = 64'hCCCC_0002; d[3] = 64'hDDDD_0003;
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'd1;
    repeat (3) begin
      edge_cycle();
      vectors += 3;
      if (mux_out !== '0) begin miscompares++; $display("FAIL reset_out: got %h expected 0", mux_out); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      if (mux_out_comb !== d[1]) begin miscompares++; $display("FAIL reset_comb: got %h expected %h", mux_out_comb, d[1]); end
    end
    rst_n = 1'b1;
    edge_cycle();
    vectors += 2;
    if (mux_out !== 64'hBBBB_0001) begin miscompares++; $display("FAIL first_capture: got %h expected %h", mux_out, 64'hBBBB_0001); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_comb_sweep();
    logic [W-1:0] want [4];
    want[0] = 64'hAAAA_0000; want[1] = 64'hBBBB_0001; want[2] = 64'hCCCC_0002; want[3] = 64'hDDDD_0003;
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      vectors++;
      if (mux_out_comb !== want[s]) begin
        miscompares++; $display("FAIL comb_sel%0d: got %h expected %h", s, mux_out_comb, want[s]);
      end
    end
    edge_cycle();
  endtask

  task automatic test_registered();
    sel = 2'd2; in_valid = 1'b1;
    edge_cycle();
    vectors += 2;
    if (mux_out !== 64'hCCCC_0002) begin miscompares++; $display("FAIL reg_capture: got %h expected %h", mux_out, 64'hCCCC_0002); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL reg_valid: got %b expected 1", out_valid); end
    in_valid = 1'b0; sel = 2'd3;
    repeat (2) begin
      edge_cycle();
      vectors += 2;
      if (mux_out !== 64'hCCCC_0002) begin miscompares++; $display("FAIL reg_hold: got %h expected %h", mux_out, 64'hCCCC_0002); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_async_reset();
    sel = 2'd3; in_valid = 1'b1;
    edge_cycle();
    vectors += 2;
    if (mux_out !== 64'hDDDD_0003) begin miscompares++; $display("FAIL pre_reset_out: got %h expected %h", mux_out, 64'hDDDD_0003); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    exp_out = '0; exp_valid = 1'b0;
    vectors += 2;
    if (mux_out !== '0) begin miscompares++; $display("FAIL async_out: got %h expected 0", mux_out); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b expected 0", out_valid); end
    edge_cycle();
    vectors++;
    if (mux_out !== '0) begin miscompares++; $display("FAIL async_hold: got %h expected 0", mux_out); end
    rst_n = 1'b1; in_valid = 1'b0;
    edge_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
      sel = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (mux_out_comb !== d[sel]) begin
        miscompares++; $display("FAIL rand_comb[%0d]: got %h expected %h", i, mux_out_comb, d[sel]);
      end
      edge_cycle();
      vectors += 2;
      if (mux_out !== exp_out) begin miscompares++; $display("FAIL rand_out[%0d]: got %h expected %h", i, mux_out, exp_out); end
      if (out_valid !== exp_valid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, exp_valid); end
    end
  endtask

`ifdef MUX4_1_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] vals [2];
    logic         want [2];
    vals[0] = 64'h7; vals[1] = 64'h3;
    want[0] = 1'b1;  want[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d[0] = vals[i]; sel = 2'd0; in_valid = 1'b1;
      edge_cycle();
      vectors += 2;
      if (mux_par !== want[i]) begin miscompares++; $display("FAIL parity[%0d]: got %b expected %b", i, mux_par, want[i]); end
      if (mux_par !== ^exp_out) begin miscompares++; $display("FAIL parity_model[%0d]: got %b expected %b", i, mux_par, ^exp_out); end
    end
    in_valid = 1'b0; d[0] = 64'h1;
    edge_cycle();
    vectors++;
    if (mux_par !== 1'b0) begin miscompares++; $display("FAIL parity_hold: got %b expected 0", mux_par); end
  endtask
`endif

  initial begin
    test_reset();
    test_comb_sweep();
    test_registered();
    test_async_reset();
    test_random();
`ifdef MUX4_1_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
